register_file_8_32: RTL and testbench
=====================================

Name: register_file_8_32

Overview:
- Single-port 8-entry x 32-bit register file with a shared address for write and read.
- CE-qualified synchronous write; combinational read of the addressed entry on Do.
- Synchronous active-high clear zeroes every entry.
- Used as small scratch or config storage inside a datapath; one clock domain.

Parameters:
- DATA_W, 32, width of each entry and of Di/Do.
- ADDR_W, 3, address width; depth = 2**ADDR_W = 8 entries.

Ports:
- clk  input  1  rising-edge clock; all state changes on posedge clk.
- clr  input  1  reset, synchronous, active-high; clears all entries.
- Address  input  ADDR_W(3)  entry select for both write and read.
- CE  input  1  write enable (chip enable for write), active-high.
- Di  input  DATA_W(32)  write data.
- Do  output  DATA_W(32)  read data = contents of entry[Address].

Behaviour:
- Interface (already decided): one clock, clk; reset clr is synchronous and active-high.
- Storage: 8 x 32-bit flops, entry[0..7]. No reset-less RAM inference; every entry must be clearable.
- Priority at posedge clk: clr=1 -> all 8 entries <= 0, and CE/Di are ignored that cycle. Else CE=1 -> entry[Address] <= Di, other entries hold. Else all entries hold.
- Reset mid-operation: clr asserted concurrently with CE=1 -> clear wins; no write occurs. Clear takes effect only at a clock edge. An asynchronous clr pulse between edges has no effect.
- Power-up: entries undefined until the first edge with clr=1. Do is X until then, or until the addressed entry is written.
- Read: Do = entry[Address], purely combinational from Address and stored state; zero-cycle address-to-data latency. No read enable; CE does not gate Do.
- Write-to-read: a write at edge N is visible on Do immediately after edge N when Address still selects that entry. Before the edge, Do shows the old value; no internal bypass.
- Reset value of Do: 0 after any clr edge, for every Address.
- Address covers all 8 entries exactly; no out-of-range case. Address wraps 7 -> 0 naturally in any counting stimulus.
- Di wider values: full 32 bits stored; no truncation or sign handling.
- X on CE or Address while clr=0: no requirement; a bench must not drive X.

Decomposition:
- Package regfile_pkg: localparams DATA_W=32, ADDR_W=3, DEPTH=8. Typedef word_t = logic [DATA_W-1:0]. Typedef addr_t = logic [ADDR_W-1:0].
- Optional sub-module reg_word: one DATA_W register with sync clr and load enable, instantiated DEPTH times via generate. The write decoder (Address + CE -> one-hot load) and the read mux stay in the top module.

Test Plan:
- Clear: clr=1 for 1 edge with CE=1, Di=32'hFFFF_FFFF -> Do=0 for Address 0..7 afterwards; no entry written.
- Write/read all: clr=0, CE=1, write Di=32'h1000_0000+k to Address k for k=0..7. Then CE=0, sweep Address -> Do=32'h1000_0000+k, combinationally in the same cycle as the address change.
- CE gating: CE=0, Address=3, Di=32'hDEAD_BEEF, edge -> entry 3 unchanged (32'h1000_0003); other entries unchanged.
- Overwrite and immediacy: Address=5, CE=1, Di=32'hA5A5_5A5A. Before the edge Do=32'h1000_0005; after the edge Do=32'hA5A5_5A5A.
- Clear priority mid-run: entries loaded; clr=1, CE=1, Address=2, Di=7, edge -> all entries 0, including entry 2.
- Counting stimulus: clr held 1; Address, CE and Di incremented each half-period (Address wraps 7->0) -> Do stays 0 throughout.

Source files
------------

// File: rtl/register_file_8_32_pkg.sv
// Shared sizes and types for the 8 x 32 register file and its users.
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

endpackage

// File: rtl/register_file_8_32_reg_word.sv
// One storage word: synchronous clear has priority over the load enable.
module reg_word
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    word_t q_reg;

    always_ff @(posedge clk) begin
        if (clr) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/register_file_8_32.sv
// 8-entry x 32-bit register file: one shared address, CE-qualified write,
// combinational read with no write-through bypass.
module register_file_8_32
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              clr,
    input  logic [ADDR_W-1:0] Address,
    input  logic              CE,
    input  logic [DATA_W-1:0] Di,
    output logic [DATA_W-1:0] Do
);

    logic [DEPTH-1:0] load_vec;
    word_t            entry_q [DEPTH];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // One-hot write decode; clear inside reg_word overrides this load.
            assign load_vec[gi] = CE && (Address == ADDR_W'(gi));

            reg_word u_word (
                .clk  (clk),
                .clr  (clr),
                .load (load_vec[gi]),
                .d    (Di),
                .q    (entry_q[gi])
            );
        end
    endgenerate

    assign Do = entry_q[Address];

endmodule

// File: tb/tb_register_file_8_32.sv
// Self-checking bench: directed vector table, hand sequences, randomized run vs array model.
module tb_register_file_8_32;
    import regfile_pkg::*;

    logic  clk = 1'b0;
    logic  clr;
    addr_t Address;
    logic  CE;
    word_t Di;
    word_t Do;

    int errors = 0;
    int checks = 0;

    word_t model [DEPTH];

    typedef struct {
        logic  clr;
        logic  ce;
        addr_t addr;
        word_t di;
        addr_t rd_addr;
        word_t exp;
    } vec_t;

    vec_t vecs [$];

    register_file_8_32 dut (
        .clk     (clk),
        .clr     (clr),
        .Address (Address),
        .CE      (CE),
        .Di      (Di),
        .Do      (Do)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input word_t exp);
        checks++;
        if (Do !== exp) begin
            errors++;
            $display("FAIL %s addr=%0d got=%h expected=%h", name, Address, Do, exp);
        end else begin
            $display("chk  %s addr=%0d do=%h", name, Address, Do);
        end
    endtask

    // One clocked transaction; the model follows the clear/write priority rules.
    task automatic drive_edge(input logic c, input logic e, input addr_t a, input word_t d);
        @(negedge clk);
        clr = c; CE = e; Address = a; Di = d;
        @(posedge clk);
        #1;
        if (c) begin
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
        end else if (e) begin
            model[a] = d;
        end
    endtask

    task automatic sweep_model(input string name);
        @(negedge clk);
        clr = 1'b0; CE = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            Address = addr_t'(i);
            #1;
            check(name, model[i]);
        end
    endtask

    function automatic vec_t mk(input logic c, input logic e, input int a, input word_t d,
                                input int ra, input word_t x);
        vec_t v;
        v.clr = c; v.ce = e; v.addr = addr_t'(a); v.di = d;
        v.rd_addr = addr_t'(ra); v.exp = x;
        return v;
    endfunction

    initial begin
        clr = 1'b0; CE = 1'b0; Address = '0; Di = '0;

        // Clear with CE high and all-ones data: nothing gets written.
        vecs.push_back(mk(1, 1, 0, 32'hFFFF_FFFF, 0, 32'h0));
        for (int k = 1; k < DEPTH; k++)
            vecs.push_back(mk(0, 0, k, 32'hFFFF_FFFF, k, 32'h0));
        for (int k = 0; k < DEPTH; k++)
            vecs.push_back(mk(0, 1, k, 32'h1000_0000 + k, k, 32'h1000_0000 + k));
        vecs.push_back(mk(0, 0, 3, 32'hDEAD_BEEF, 3, 32'h1000_0003));
        for (int k = 0; k < DEPTH; k++)
            vecs.push_back(mk(0, 0, k, 32'hDEAD_BEEF, k, 32'h1000_0000 + k));
        vecs.push_back(mk(0, 1, 6, 32'hCAFE_0006, 6, 32'hCAFE_0006));
        vecs.push_back(mk(1, 1, 2, 32'h0000_0007, 2, 32'h0));
        for (int k = 0; k < DEPTH; k++)
            vecs.push_back(mk(0, 0, k, 32'h1234_5678, k, 32'h0));

        foreach (vecs[i]) begin
            drive_edge(vecs[i].clr, vecs[i].ce, vecs[i].addr, vecs[i].di);
            CE = 1'b0;
            Address = vecs[i].rd_addr;
            #1;
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // Load all entries, then sweep reads combinationally.
        for (int k = 0; k < DEPTH; k++) drive_edge(1'b0, 1'b1, addr_t'(k), 32'h1000_0000 + k);
        sweep_model("read_all");

        // Write visibility: old value before the edge, new value right after.
        @(negedge clk);
        clr = 1'b0; CE = 1'b1; Address = 3'd5; Di = 32'hA5A5_5A5A;
        #1;
        check("pre_edge_old", 32'h1000_0005);
        @(posedge clk);
        #1;
        model[5] = 32'hA5A5_5A5A;
        check("post_edge_new", 32'hA5A5_5A5A);
        CE = 1'b0;

        // A clr pulse between edges must not clear anything.
        @(negedge clk);
        Address = 3'd5;
        #1 clr = 1'b1;
        #2 clr = 1'b0;
        @(posedge clk);
        #1;
        check("glitch_clr_ignored", 32'hA5A5_5A5A);
        sweep_model("after_glitch");

        // Clear held while Address/CE/Di count every half period.
        drive_edge(1'b1, 1'b1, 3'd0, 32'h0);
        @(negedge clk);
        #2;
        for (int n = 0; n < 20; n++) begin
            Address = Address + 3'd1;
            CE = ~CE;
            Di = Di + 32'd1;
            #1;
            check("count_clr", 32'h0);
            #4;
        end
        clr = 1'b0; CE = 1'b0;
        sweep_model("after_count");

        // Randomized operations against the array model.
        for (int n = 0; n < 300; n++) begin
            logic  c;
            logic  e;
            addr_t a;
            word_t d;
            c = ($urandom_range(0, 19) == 0);
            e = $urandom_range(0, 1) == 1;
            a = addr_t'($urandom_range(0, DEPTH - 1));
            d = $urandom;
            drive_edge(c, e, a, d);
            CE = 1'b0;
            Address = addr_t'($urandom_range(0, DEPTH - 1));
            #1;
            check("rand", model[Address]);
            if (n % 50 == 49) sweep_model("rand_sweep");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
